// File: rtl/cpu_pkg.sv
// Shared widths and enumerations for the instruction-fetch slice.
package cpu_pkg;

   localparam int PC_W    = 12;
   localparam int INSTR_W = 19;

   typedef enum logic [1:0] {
      RK_JMP  = 2'd0,
      RK_CALL = 2'd1,
      RK_RET  = 2'd2,
      RK_RSVD = 2'd3
   } redirect_kind_e;

   typedef enum logic [1:0] {
      FS_START  = 2'd0,
      FS_RUN    = 2'd1,
      FS_BUBBLE = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/return_stack.sv
// Circular return-address stack; a push onto a full stack overwrites the oldest entry.
module return_stack
   import cpu_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            push,
   input  logic            pop,
   input  logic [PC_W-1:0] push_data,
   output logic [PC_W-1:0] pop_data,
   output logic            empty,
   output logic            full,
   output logic            overflow_evt
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [PC_W-1:0]  mem [DEPTH];
   logic [PTR_W-1:0] top_reg, top_next;
   logic [PTR_W:0]   count_reg, count_next;

   assign empty        = (count_reg == '0);
   assign full         = (count_reg == (PTR_W+1)'(DEPTH));
   assign overflow_evt = push & full;
   assign pop_data     = mem[top_reg];

   always_comb begin
      top_next   = top_reg;
      count_next = count_reg;
      if (push) begin
         // When full, top+1 lands on the oldest slot, so the wrap discards it.
         top_next = top_reg + PTR_W'(1);
         if (!full) begin
            count_next = count_reg + (PTR_W+1)'(1);
         end
      end else if (pop && !empty) begin
         top_next   = top_reg - PTR_W'(1);
         count_next = count_reg - (PTR_W+1)'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         top_reg   <= '0;
         count_reg <= '0;
      end else begin
         top_reg   <= top_next;
         count_reg <= count_next;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[top_next] <= push_data;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: program counter, IF/ID register, redirect handling and RAS flags.
module fetch_unit
   import cpu_pkg::*;
#(
   parameter logic [PC_W-1:0] RESET_PC  = 12'd0,
   parameter int              RAS_DEPTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   output logic [PC_W-1:0]    address,
   input  logic [INSTR_W-1:0] instruction,
   input  logic               stall,
   input  logic               redirect_valid,
   input  logic [1:0]         redirect_kind,
   input  logic [PC_W-1:0]    redirect_target,
   output logic [INSTR_W-1:0] fetch_instruction,
   output logic [PC_W-1:0]    fetch_pc,
   output logic               fetch_valid,
   output logic               ras_overflow,
   output logic               ras_underflow
);

   fetch_state_e        state_reg, state_next;
   logic [PC_W-1:0]     pc_reg, pc_next;
   logic [PC_W-1:0]     fpc_reg, fpc_next;
   logic [INSTR_W-1:0]  finstr_reg, finstr_next;
   logic                fvalid_reg, fvalid_next;
   logic                ovf_reg, ovf_next;
   logic                unf_reg, unf_next;

   redirect_kind_e      kind;
   logic                take_redirect;
   logic                ras_push, ras_pop;
   logic                ras_empty, ras_full, ras_ovf_evt;
   logic [PC_W-1:0]     ras_pop_data, ret_addr, redirect_pc;

   assign kind = redirect_kind_e'(redirect_kind);

   // Only a valid instruction in IF/ID may redirect; the bubble slot never does.
   assign take_redirect = (state_reg == FS_RUN) && fvalid_reg && redirect_valid;
   assign ret_addr      = fpc_reg + PC_W'(1);
   assign ras_push      = take_redirect && (kind == RK_CALL);
   assign ras_pop       = take_redirect && (kind == RK_RET) && !ras_empty;

   always_comb begin
      redirect_pc = redirect_target;
      if (kind == RK_RET) begin
         redirect_pc = ras_empty ? ret_addr : ras_pop_data;
      end
   end

   return_stack #(
      .DEPTH(RAS_DEPTH)
   ) u_ras (
      .clk         (clk),
      .rst         (rst),
      .push        (ras_push),
      .pop         (ras_pop),
      .push_data   (ret_addr),
      .pop_data    (ras_pop_data),
      .empty       (ras_empty),
      .full        (ras_full),
      .overflow_evt(ras_ovf_evt)
   );

   always_comb begin
      state_next  = state_reg;
      pc_next     = pc_reg;
      fpc_next    = fpc_reg;
      finstr_next = finstr_reg;
      fvalid_next = fvalid_reg;
      ovf_next    = ovf_reg | (ras_ovf_evt & ras_full);
      unf_next    = unf_reg | (take_redirect && (kind == RK_RET) && ras_empty);

      case (state_reg)
         FS_RUN: begin
            if (take_redirect) begin
               pc_next     = redirect_pc;
               fvalid_next = 1'b0;
               state_next  = FS_BUBBLE;
            end else if (!stall) begin
               finstr_next = instruction;
               fpc_next    = pc_reg;
               fvalid_next = 1'b1;
               pc_next     = pc_reg + PC_W'(1);
            end
         end
         default: begin
            // START and BUBBLE both fetch normally and ignore redirects.
            if (!stall) begin
               finstr_next = instruction;
               fpc_next    = pc_reg;
               fvalid_next = 1'b1;
               pc_next     = pc_reg + PC_W'(1);
               state_next  = FS_RUN;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg  <= FS_START;
         pc_reg     <= RESET_PC;
         fpc_reg    <= '0;
         finstr_reg <= '0;
         fvalid_reg <= 1'b0;
         ovf_reg    <= 1'b0;
         unf_reg    <= 1'b0;
      end else begin
         state_reg  <= state_next;
         pc_reg     <= pc_next;
         fpc_reg    <= fpc_next;
         finstr_reg <= finstr_next;
         fvalid_reg <= fvalid_next;
         ovf_reg    <= ovf_next;
         unf_reg    <= unf_next;
      end
   end

   assign address           = pc_reg;
   assign fetch_pc          = fpc_reg;
   assign fetch_instruction = finstr_reg;
   assign fetch_valid       = fvalid_reg;
   assign ras_overflow      = ovf_reg;
   assign ras_underflow     = unf_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected fetch results are queued per cycle and popped after each edge.
module tb_fetch_unit;
   import cpu_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [11:0] address;
   logic [18:0] instruction;
   logic        stall;
   logic        redirect_valid;
   logic [1:0]  redirect_kind;
   logic [11:0] redirect_target;
   logic [18:0] fetch_instruction;
   logic [11:0] fetch_pc;
   logic        fetch_valid;
   logic        ras_overflow;
   logic        ras_underflow;

   bit          const_mode;
   int          errors = 0;
   int          checks = 0;

   typedef struct {
      logic        valid;
      logic [11:0] fpc;
      logic [11:0] addr;
      logic [18:0] instr;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   // Instruction memory model: constant word or an address-tagged pattern.
   assign instruction = const_mode ? 19'h0000A : {7'h35, address};

   fetch_unit #(
      .RESET_PC (12'd0),
      .RAS_DEPTH(8)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .address          (address),
      .instruction      (instruction),
      .stall            (stall),
      .redirect_valid   (redirect_valid),
      .redirect_kind    (redirect_kind),
      .redirect_target  (redirect_target),
      .fetch_instruction(fetch_instruction),
      .fetch_pc         (fetch_pc),
      .fetch_valid      (fetch_valid),
      .ras_overflow     (ras_overflow),
      .ras_underflow    (ras_underflow)
   );

   function automatic logic [18:0] mem_word(input logic [11:0] a);
      if (const_mode) return 19'h0000A;
      return {7'h35, a};
   endfunction

   task automatic expect_fetch(input logic [11:0] fpc, input logic [11:0] addr);
      sb.push_back('{1'b1, fpc, addr, mem_word(fpc)});
   endtask

   task automatic expect_bubble(input logic [11:0] addr);
      sb.push_back('{1'b0, 12'd0, addr, 19'd0});
   endtask

   task automatic cycle(input logic st, input logic rv, input logic [1:0] kind,
                        input logic [11:0] tgt, input string tag);
      exp_t e;
      stall           = st;
      redirect_valid  = rv;
      redirect_kind   = kind;
      redirect_target = tgt;
      @(posedge clk);
      #1;
      $display("txn %s: stall=%0b rv=%0b kind=%0d tgt=%0d -> addr=%0d fpc=%0d valid=%0b instr=%h",
               tag, st, rv, kind, tgt, address, fetch_pc, fetch_valid, fetch_instruction);
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s: scoreboard empty, no expectation for this cycle", tag);
      end else begin
         e = sb.pop_front();
         checks++;
         if (address !== e.addr) begin
            errors++;
            $display("FAIL %s address: got %0d expected %0d", tag, address, e.addr);
         end
         checks++;
         if (fetch_valid !== e.valid) begin
            errors++;
            $display("FAIL %s fetch_valid: got %b expected %b", tag, fetch_valid, e.valid);
         end
         if (e.valid) begin
            checks++;
            if (fetch_pc !== e.fpc) begin
               errors++;
               $display("FAIL %s fetch_pc: got %0d expected %0d", tag, fetch_pc, e.fpc);
            end
            checks++;
            if (fetch_instruction !== e.instr) begin
               errors++;
               $display("FAIL %s fetch_instruction: got %h expected %h", tag, fetch_instruction, e.instr);
            end
         end
      end
   endtask

   task automatic check_flags(input logic ovf, input logic unf, input string tag);
      checks++;
      if (ras_overflow !== ovf) begin
         errors++;
         $display("FAIL %s ras_overflow: got %b expected %b", tag, ras_overflow, ovf);
      end
      checks++;
      if (ras_underflow !== unf) begin
         errors++;
         $display("FAIL %s ras_underflow: got %b expected %b", tag, ras_underflow, unf);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      checks++;
      if (address !== 12'd0) begin
         errors++;
         $display("FAIL %s address: got %0d expected 0", tag, address);
      end
      checks++;
      if (fetch_valid !== 1'b0) begin
         errors++;
         $display("FAIL %s fetch_valid: got %b expected 0", tag, fetch_valid);
      end
      checks++;
      if (fetch_pc !== 12'd0) begin
         errors++;
         $display("FAIL %s fetch_pc: got %0d expected 0", tag, fetch_pc);
      end
      checks++;
      if (fetch_instruction !== 19'd0) begin
         errors++;
         $display("FAIL %s fetch_instruction: got %h expected 0", tag, fetch_instruction);
      end
      check_flags(1'b0, 1'b0, tag);
   endtask

   task automatic test_reset();
      rst             = 1'b0;
      stall           = 1'b0;
      redirect_valid  = 1'b0;
      redirect_kind   = 2'd0;
      redirect_target = 12'd0;
      const_mode      = 1'b1;
      #12;
      check_reset_outputs("reset");
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   task automatic test_free_run();
      for (int i = 0; i < 4; i++) begin
         expect_fetch(12'(i), 12'(i + 1));
         cycle(1'b0, 1'b0, RK_JMP, 12'd0, "free_run");
      end
   endtask

   task automatic test_stall();
      const_mode = 1'b0;
      expect_fetch(12'd4, 12'd5);
      cycle(1'b0, 1'b0, RK_JMP, 12'd0, "stall_pre");
      for (int i = 0; i < 3; i++) begin
         expect_fetch(12'd4, 12'd5);
         cycle(1'b1, 1'b0, RK_JMP, 12'd0, "stall_hold");
      end
      expect_fetch(12'd5, 12'd6);
      cycle(1'b0, 1'b0, RK_JMP, 12'd0, "stall_release");
      expect_fetch(12'd6, 12'd7);
      cycle(1'b0, 1'b0, RK_JMP, 12'd0, "stall_release");
   endtask

   task automatic test_jmp();
      for (int f = 7; f <= 9; f++) begin
         expect_fetch(12'(f), 12'(f + 1));
         cycle(1'b0, 1'b0, RK_JMP, 12'd0, "jmp_pre");
      end
      expect_bubble(12'd15);
      cycle(1'b0, 1'b1, RK_JMP, 12'd15, "jmp");
      expect_fetch(12'd15, 12'd16);
      cycle(1'b0, 1'b0, RK_JMP, 12'd0, "jmp_target");
      // Redirect wins over a simultaneous stall.
      expect_bubble(12'd15);
      cycle(1'b1, 1'b1, RK_JMP, 12'd15, "jmp_stall");
      // A redirect presented while IF/ID is the bubble must be ignored.
      expect_fetch(12'd15, 12'd16);
      cycle(1'b0, 1'b1, RK_JMP, 12'd300, "jmp_in_bubble");
      expect_bubble(12'd40);
      cycle(1'b0, 1'b1, RK_RSVD, 12'd40, "jmp_rsvd");
      expect_fetch(12'd40, 12'd41);
      cycle(1'b0, 1'b0, RK_JMP, 12'd0, "jmp_rsvd_target");
   endtask

   task automatic test_call_ret();
      expect_bubble(12'd20);
      cycle(1'b0, 1'b1, RK_JMP, 12'd20, "call_setup");
      expect_fetch(12'd20, 12'd21);
      cycle(1'b0, 1'b0, RK_JMP, 12'd0, "call_setup");
      expect_bubble(12'd100);
      cycle(1'b0, 1'b1, RK_CALL, 12'd100, "call");
      for (int f = 100; f <= 102; f++) begin
         expect_fetch(12'(f), 12'(f + 1));
         cycle(1'b0, 1'b0, RK_JMP, 12'd0, "callee");
      end
      expect_bubble(12'd21);
      cycle(1'b0, 1'b1, RK_RET, 12'hABC, "ret");
      expect_fetch(12'd21, 12'd22);
      cycle(1'b0, 1'b0, RK_JMP, 12'd0, "ret_target");
      check_flags(1'b0, 1'b0, "call_ret_flags");
   endtask

   task automatic test_ras_nested();
      logic [11:0] t;
      logic [11:0] r;
      for (int i = 0; i < 9; i++) begin
         t = 12'(200 + 16 * i);
         expect_bubble(t);
         cycle(1'b0, 1'b1, RK_CALL, t, "nest_call");
         expect_fetch(t, t + 12'd1);
         cycle(1'b0, 1'b0, RK_JMP, 12'd0, "nest_callee");
         if (i == 7) check_flags(1'b0, 1'b0, "ras_full_no_ovf");
      end
      check_flags(1'b1, 1'b0, "ras_ovf");
      for (int j = 0; j < 8; j++) begin
         r = 12'(200 + 16 * (7 - j) + 1);
         expect_bubble(r);
         cycle(1'b0, 1'b1, RK_RET, 12'h777, "nest_ret");
         expect_fetch(r, r + 12'd1);
         cycle(1'b0, 1'b0, RK_JMP, 12'd0, "nest_ret_target");
      end
      check_flags(1'b1, 1'b0, "ras_drained");
      expect_bubble(12'd202);
      cycle(1'b0, 1'b1, RK_RET, 12'h777, "ret_underflow");
      expect_fetch(12'd202, 12'd203);
      cycle(1'b0, 1'b0, RK_JMP, 12'd0, "ret_underflow_target");
      check_flags(1'b1, 1'b1, "ras_unf");
   endtask

   task automatic test_wrap();
      expect_bubble(12'd4094);
      cycle(1'b0, 1'b1, RK_JMP, 12'd4094, "wrap_setup");
      expect_fetch(12'd4094, 12'd4095);
      cycle(1'b0, 1'b0, RK_JMP, 12'd0, "wrap");
      expect_fetch(12'd4095, 12'd0);
      cycle(1'b0, 1'b0, RK_JMP, 12'd0, "wrap");
      expect_fetch(12'd0, 12'd1);
      cycle(1'b0, 1'b0, RK_JMP, 12'd0, "wrap");
      expect_bubble(12'd4095);
      cycle(1'b0, 1'b1, RK_JMP, 12'd4095, "wrap_ret_setup");
      expect_fetch(12'd4095, 12'd0);
      cycle(1'b0, 1'b0, RK_JMP, 12'd0, "wrap_ret_setup");
      // Empty-RAS return falls through to fetch_pc+1, which wraps to 0.
      expect_bubble(12'd0);
      cycle(1'b0, 1'b1, RK_RET, 12'h123, "wrap_ret");
      expect_fetch(12'd0, 12'd1);
      cycle(1'b0, 1'b0, RK_JMP, 12'd0, "wrap_ret_target");
   endtask

   task automatic test_reset_mid();
      stall           = 1'b0;
      redirect_valid  = 1'b1;
      redirect_kind   = RK_JMP;
      redirect_target = 12'd500;
      #2;
      rst = 1'b0;
      #1;
      check_reset_outputs("reset_async");
      @(posedge clk);
      #1;
      check_reset_outputs("reset_held");
      rst            = 1'b1;
      redirect_valid = 1'b0;
      expect_fetch(12'd0, 12'd1);
      cycle(1'b0, 1'b0, RK_JMP, 12'd0, "after_reset");
      expect_fetch(12'd1, 12'd2);
      cycle(1'b0, 1'b0, RK_JMP, 12'd0, "after_reset");
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
      end
   endtask

   initial begin
      test_reset();
      test_free_run();
      test_stall();
      test_jmp();
      test_call_ret();
      test_ras_nested();
      test_wrap();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the 4096 x 19-bit instruction memory.
- Owns the 12-bit program counter and drives the memory address.
- Captures the 19-bit instruction returned in the same cycle into an IF/ID pipeline register.
- Handles stall, JMP/CALL/RET redirects from decode, and a small return-address stack (RAS).

Parameters:
- RESET_PC, 12'd0, PC value loaded on reset.
- RAS_DEPTH, 8, number of return-address stack entries (power of two, 2..16).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- address  out  12  instruction memory address; always equals the pc register.
- instruction  in  19  instruction memory read data; combinational from address, valid in the same cycle.
- stall  in  1  hold pc and IF/ID contents.
- redirect_valid  in  1  decode requests a control transfer for the instruction in IF/ID.
- redirect_kind  in  2  0 = JMP, 1 = CALL, 2 = RET, 3 = reserved (treated as JMP).
- redirect_target  in  12  destination for JMP/CALL; ignored for RET.
- fetch_instruction  out  19  IF/ID instruction.
- fetch_pc  out  12  address of fetch_instruction.
- fetch_valid  out  1  IF/ID holds a real instruction.
- ras_overflow  out  1  sticky: a CALL was pushed onto a full RAS.
- ras_underflow  out  1  sticky: a RET popped an empty RAS.

Behaviour:
- Reset (rst = 0, asynchronous):
  - pc = RESET_PC; fetch_instruction = 0; fetch_pc = 0; fetch_valid = 0.
  - RAS count = 0; both sticky flags = 0; state = START.
- States:
  - START: one cycle after reset release. pc is held; IF/ID loads instruction at pc with fetch_valid = 1; pc <= pc+1; go to RUN. Stall in START holds state.
  - RUN, normal step (no stall, no redirect): IF/ID <= {instruction, pc, valid = 1}; pc <= pc+1.
  - RUN, stall only: pc, IF/ID, RAS and flags unchanged.
  - RUN, redirect_valid = 1:
    - pc <= target; IF/ID valid <= 0 (squash the wrong-path fetch).
    - Go to BUBBLE for exactly one cycle.
    - Redirect has priority over stall.
  - BUBBLE: behaves as RUN; fetch_valid = 1 from the following edge. A redirect in BUBBLE is ignored, because IF/ID is invalid.
- Targets:
  - JMP: target = redirect_target.
  - CALL: push fetch_pc+1 (mod 4096); target = redirect_target.
  - RET with count > 0: pop; target = popped value.
  - RET with count = 0: target = fetch_pc+1; ras_underflow <= 1.
- RAS storage:
  - Circular, RAS_DEPTH entries, top pointer plus count saturating at RAS_DEPTH.
  - Push when full: overwrite the oldest entry; count stays at RAS_DEPTH; ras_overflow <= 1.
  - Pop decrements count.
- Wrap-around: pc 4095 + 1 = 0 with no flag. fetch_pc+1 likewise wraps.
- A redirect arriving while fetch_valid = 0 is ignored, including any RAS side effect.
- Reset asserted mid-operation: immediate return to reset values; a pending redirect is lost.
- Latency: instruction at address A appears on fetch_instruction one edge after pc = A. Redirect-to-valid target instruction is 2 edges.
- Sticky flags clear only on reset.

Decomposition:
- Shared package cpu_pkg:
  - PC_W = 12, INSTR_W = 19.
  - Typedef redirect_kind_e {RK_JMP, RK_CALL, RK_RET, RK_RSVD}.
  - Typedef fetch_state_e {FS_START, FS_RUN, FS_BUBBLE}.
- Sub-module return_stack holds the circular RAS:
  - Inputs: push, pop, push_data.
  - Outputs: pop_data, empty, full, overflow_evt.
- fetch_unit holds pc, IF/ID, FSM and flags.

Test Plan:
- Reset, then free-run with memory returning 19'h0000A at every address -> address steps 0,1,2,3; fetch_valid rises one edge after reset release; fetch_pc = 0,1,2.
- Stall held 3 cycles at pc = 5 -> address stays 5; fetch_pc stays 4; after release, fetch_pc = 5 then 6.
- JMP target 12'd15 while fetch_pc = 9 -> next cycle fetch_valid = 0 and address = 15; following cycle fetch_pc = 15 with fetch_valid = 1. Repeat with stall = 1 simultaneously -> same result.
- CALL target 100 at fetch_pc = 20, then RET at fetch_pc = 102 -> address goes to 100, later to 21; ras_underflow = 0.
- 9 nested CALLs (RAS_DEPTH = 8), then 9 RETs -> ras_overflow = 1; the first 8 RETs return innermost-first; the 9th RET falls through to fetch_pc+1 and sets ras_underflow = 1.
- pc = 4095 free-run -> address 0 next; fetch_pc = 4095 is followed by fetch_pc = 0. Assert rst mid-redirect -> all outputs return to reset values asynchronously.
